// File: rtl/ps2kb_tx.sv
// Host-to-device PS/2 transmitter: sends one command byte to a keyboard over the
// open-collector ps2c/ps2d pair (oe=1 means pull low). Times out if the device stalls.
module ps2kb_tx #(
  parameter int RTS_CYCLES     = 6000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       rx_en,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       tx_err
);

  localparam int MAX_CYCLES = (RTS_CYCLES > TIMEOUT_CYCLES) ? RTS_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] RTS_LOAD = CW'(RTS_CYCLES - 1);
  localparam logic [CW-1:0] TO_LOAD  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_RTS, S_START, S_DATA, S_STOP, S_DONE
  } state_t;

  state_t        state_reg, state_next;
  logic [3:0]    filter_reg, filter_next;
  logic          f_clk_reg, f_clk_next;
  logic          d_meta_reg, d_sync_reg;
  logic [8:0]    sreg_reg, sreg_next;
  logic [3:0]    n_reg, n_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          err_reg, err_next;
  logic          fall_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      filter_reg <= 4'b1111;
      f_clk_reg  <= 1'b1;
      d_meta_reg <= 1'b1;
      d_sync_reg <= 1'b1;
      sreg_reg   <= '0;
      n_reg      <= '0;
      cnt_reg    <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      filter_reg <= filter_next;
      f_clk_reg  <= f_clk_next;
      d_meta_reg <= ps2d;
      d_sync_reg <= d_meta_reg;
      sreg_reg   <= sreg_next;
      n_reg      <= n_next;
      cnt_reg    <= cnt_next;
      err_reg    <= err_next;
    end
  end

  // Glitch filter: the clock only changes after four agreeing samples.
  always_comb begin
    filter_next = {ps2c, filter_reg[3:1]};
    if (filter_next == 4'b1111)
      f_clk_next = 1'b1;
    else if (filter_next == 4'b0000)
      f_clk_next = 1'b0;
    else
      f_clk_next = f_clk_reg;
  end

  assign fall_edge = f_clk_reg & ~f_clk_next;

  always_comb begin
    state_next   = state_reg;
    sreg_next    = sreg_reg;
    n_next       = n_reg;
    cnt_next     = cnt_reg;
    err_next     = err_reg;
    ps2c_oe      = 1'b0;
    ps2d_oe      = 1'b0;
    tx_idle      = 1'b0;
    tx_done_tick = 1'b0;

    // Device-clocked states share one watchdog, re-armed by every falling edge.
    if (state_reg == S_START || state_reg == S_DATA || state_reg == S_STOP) begin
      if (fall_edge) begin
        cnt_next = TO_LOAD;
      end else if (cnt_reg == '0) begin
        err_next   = 1'b1;
        state_next = S_DONE;
      end else begin
        cnt_next = cnt_reg - CNT_ONE;
      end
    end

    case (state_reg)
      S_IDLE: begin
        tx_idle = 1'b1;
        if (wr_ps2) begin
          sreg_next  = {~^din, din};
          n_next     = 4'd8;
          cnt_next   = RTS_LOAD;
          err_next   = 1'b0;
          state_next = S_RTS;
        end
      end
      S_RTS: begin
        ps2c_oe = 1'b1;
        if (cnt_reg == '0) begin
          cnt_next   = TO_LOAD;
          state_next = S_START;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end
      S_START: begin
        ps2d_oe = 1'b1;
        if (fall_edge)
          state_next = S_DATA;
      end
      S_DATA: begin
        ps2d_oe = ~sreg_reg[0];
        if (fall_edge) begin
          sreg_next = {1'b0, sreg_reg[8:1]};
          if (n_reg == 4'd0)
            state_next = S_STOP;
          else
            n_next = n_reg - 4'd1;
        end
      end
      S_STOP: begin
        // Stop bit is released after the 10th fall; the 11th fall carries the ACK.
        if (fall_edge) begin
          err_next   = d_sync_reg;
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        tx_done_tick = 1'b1;
        state_next   = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign rx_en  = tx_idle;
  assign tx_err = err_reg;

endmodule

// File: tb/tb_ps2kb_tx.sv
// Directed bench for ps2kb_tx: a keyboard model clocks frames while a scoreboard
// queue supplies the expected line bits and error status of each transfer.
module tb_ps2kb_tx;

  localparam int RTS = 40;
  localparam int TO  = 200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_ps2 = 1'b0;
  logic [7:0] din = 8'h00;
  logic       dev_c = 1'b1;
  logic       dev_d = 1'b1;
  logic       ps2c_oe, ps2d_oe, rx_en, tx_idle, tx_done_tick, tx_err;
  wire        ps2c_w, ps2d_w;

  // Open-collector pads: either side can only pull low.
  assign ps2c_w = dev_c & ~ps2c_oe;
  assign ps2d_w = dev_d & ~ps2d_oe;

  ps2kb_tx #(.RTS_CYCLES(RTS), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .wr_ps2(wr_ps2), .din(din),
    .ps2c(ps2c_w), .ps2d(ps2d_w),
    .ps2c_oe(ps2c_oe), .ps2d_oe(ps2d_oe), .rx_en(rx_en),
    .tx_idle(tx_idle), .tx_done_tick(tx_done_tick), .tx_err(tx_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_fall_cyc = 0;
  bit exp_bits[$];
  bit exp_err[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (tx_done_tick) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue a write, queue the expected frame, and measure the request-to-send hold.
  task automatic request(input logic [7:0] b, input bit err);
    int w;
    int n;
    w = 0;
    while (!tx_idle && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check("idle_before_wr", tx_idle, 1);
    @(negedge clk);
    din = b;
    wr_ps2 = 1'b1;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
    exp_bits.push_back(~^b);
    exp_bits.push_back(1'b1);
    exp_err.push_back(err);
    @(posedge clk); #1;
    wr_ps2 = 1'b0;
    check("rts_latency", ps2c_oe, 1);
    check("rx_en_busy", rx_en, 0);
    n = 1;
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk); #1;
      if (!ps2c_oe) break;
      n++;
    end
    check("rts_len", n, RTS);
  endtask

  // Keyboard model: one bit per 16-cycle clock period, line sampled before each fall.
  task automatic device(input int falls, input bit ack, input bit glitch);
    logic got;
    bit   exp;
    repeat (6) @(negedge clk);
    if (glitch) begin
      dev_c = 1'b0;
      repeat (2) @(negedge clk);
      dev_c = 1'b1;
      repeat (6) @(negedge clk);
      check("glitch_no_edge", ps2d_oe, 1);
    end
    for (int k = 0; k < falls; k++) begin
      got = ps2d_w;
      exp = exp_bits.pop_front();
      check($sformatf("bit%0d", k), got, exp);
      if (k == 10 && ack) dev_d = 1'b0;
      dev_c = 1'b0;
      last_fall_cyc = cyc;
      repeat (8) @(negedge clk);
      dev_c = 1'b1;
      dev_d = 1'b1;
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic tx_frame(input logic [7:0] b, input bit ack, input bit glitch);
    int d0;
    d0 = done_cnt;
    request(b, !ack);
    device(11, ack, glitch);
    check($sformatf("done_once_%0h", b), done_cnt - d0, 1);
    check($sformatf("tx_err_%0h", b), tx_err, exp_err.pop_front());
    check("done_latency", done_cyc - last_fall_cyc, 4);
    check("idle_after", tx_idle, 1);
  endtask

  initial begin
    int d0;
    int n;
    bit rx_low;

    repeat (3) @(negedge clk);
    check("rst_c_oe", ps2c_oe, 0);
    check("rst_d_oe", ps2d_oe, 0);
    check("rst_idle", tx_idle, 1);
    check("rst_rx_en", rx_en, 1);
    check("rst_done", tx_done_tick, 0);
    check("rst_err", tx_err, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    tx_frame(8'hED, 1'b1, 1'b0);
    tx_frame(8'h00, 1'b1, 1'b1);
    tx_frame(8'hFF, 1'b1, 1'b0);
    tx_frame(8'h5A, 1'b0, 1'b0);

    // Silent device: abort after the watchdog expires; a mid-frame write is dropped.
    d0 = done_cnt;
    request(8'h33, 1'b1);
    exp_bits.delete();
    rx_low = 1'b1;
    n = 1;
    for (int i = 0; i < 10000; i++) begin
      if (i == 50) begin
        din = 8'h99;
        wr_ps2 = 1'b1;
      end
      @(posedge clk); #1;
      wr_ps2 = 1'b0;
      if (!ps2d_oe) break;
      if (rx_en) rx_low = 1'b0;
      n++;
    end
    check("timeout_len", n, TO);
    check("rx_en_low_frame", rx_low, 1);
    check("to_c_oe", ps2c_oe, 0);
    check("to_d_oe", ps2d_oe, 0);
    @(posedge clk); #1;
    check("to_err", tx_err, exp_err.pop_front());
    check("to_idle", tx_idle, 1);
    check("to_done_once", done_cnt - d0, 1);
    repeat (5) @(negedge clk);
    check("wr_ignored", ps2c_oe, 0);

    // Reset in the middle of the data bits.
    request(8'hA5, 1'b0);
    device(4, 1'b0, 1'b0);
    check("pre_reset_d", ps2d_oe, 1);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check("arst_c_oe", ps2c_oe, 0);
    check("arst_d_oe", ps2d_oe, 0);
    check("arst_idle", tx_idle, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("arst_no_done", done_cnt - d0, 0);
    check("arst_err", tx_err, 0);
    exp_bits.delete();
    void'(exp_err.pop_front());

    tx_frame(8'hED, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

endmodule
